// File: rtl/td4_port_monitor.sv
// Host-side peer of the TD4 I/O ports: drives in_port and logs timestamped out_port changes in a FIFO.
// Define TD4_PORT_MON_PC_EN to record pc_out in each entry; otherwise the pc field reads zero.
module td4_port_monitor #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 12
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [3:0]               i_out_port,
    input  logic [3:0]               i_pc_out,
    output logic [3:0]               o_in_port,
    input  logic [3:0]               i_host_in_data,
    input  logic                     i_host_in_we,
    output logic [TS_W+7:0]          o_cap_data,
    output logic                     o_cap_valid,
    input  logic                     i_cap_ready,
    output logic [$clog2(DEPTH):0]   o_cap_count,
    output logic                     o_overflow,
    input  logic                     i_clear
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [TS_W+7:0] r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    logic [TS_W-1:0] r_ts;
    logic [3:0]      r_prev;
    logic [3:0]      r_in_port;
    logic            r_overflow;
    logic [TS_W+7:0] r_cap_data;

    logic [3:0]      w_pc;
    logic [TS_W+7:0] w_entry;
    logic            w_change;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic [AW-1:0]   w_rd_next;
    logic [AW-1:0]   w_wr_next;
    logic [AW:0]     w_count_next;
    logic [TS_W+7:0] w_head_next;

`ifdef TD4_PORT_MON_PC_EN
    assign w_pc = i_pc_out;
`else
    logic w_unused_pc;
    assign w_unused_pc = ^i_pc_out;
    assign w_pc        = 4'b0000;
`endif

    assign w_entry = {r_ts, w_pc, i_out_port};

    always_comb begin
        w_change     = (i_out_port != r_prev);
        w_pop        = (r_count != '0) && i_cap_ready;
        w_full       = (r_count == FULL_COUNT);
        // A pop frees the slot the push needs, so full+pop+change is accepted.
        w_push       = w_change && (!w_full || w_pop);
        w_drop       = w_change && w_full && !w_pop;
        w_rd_next    = w_pop  ? r_rd_ptr + 1'b1 : r_rd_ptr;
        w_wr_next    = w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
        // The new entry becomes head only when nothing older remains after this edge.
        w_head_next = (w_push && (r_wr_ptr == w_rd_next)) ? w_entry : r_mem[w_rd_next];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_ts       <= '0;
            r_prev     <= '0;
            r_in_port  <= '0;
            r_overflow <= 1'b0;
            r_cap_data <= '0;
        end else begin
            r_ts   <= r_ts + 1'b1;
            r_prev <= i_out_port;
            if (i_host_in_we) begin
                r_in_port <= i_host_in_data;
            end
            if (i_clear) begin
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_cap_data <= '0;
            end else begin
                r_rd_ptr   <= w_rd_next;
                r_wr_ptr   <= w_wr_next;
                r_count    <= w_count_next;
                r_cap_data <= w_head_next;
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset && !i_clear && w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign o_in_port   = r_in_port;
    assign o_cap_data  = r_cap_data;
    assign o_cap_valid = (r_count != '0);
    assign o_cap_count = r_count;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_td4_port_monitor.sv
// Randomized self-checking bench for td4_port_monitor against a queue-based reference model.
module tb_td4_port_monitor;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TS_W   = 12;
    localparam int          TS_MOD = 1 << TS_W;
`ifdef TD4_PORT_MON_PC_EN
    localparam bit PcEn = 1'b1;
`else
    localparam bit PcEn = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic [3:0]            out_port;
    logic [3:0]            pc_out;
    logic [3:0]            in_port;
    logic [3:0]            host_data;
    logic                  host_we;
    logic [TS_W+7:0]       cap_data;
    logic                  cap_valid;
    logic                  cap_ready;
    logic [$clog2(DEPTH):0] cap_count;
    logic                  overflow;
    logic                  clr;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [TS_W+7:0] mq[$];
    int              m_ts;
    logic [3:0]      m_prev;
    logic            m_ovf;
    logic [3:0]      m_in;

    td4_port_monitor #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_out_port     (out_port),
        .i_pc_out       (pc_out),
        .o_in_port      (in_port),
        .i_host_in_data (host_data),
        .i_host_in_we   (host_we),
        .o_cap_data     (cap_data),
        .o_cap_valid    (cap_valid),
        .i_cap_ready    (cap_ready),
        .o_cap_count    (cap_count),
        .o_overflow     (overflow),
        .i_clear        (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] pcx(input logic [3:0] pc);
        return PcEn ? pc : 4'h0;
    endfunction

    // Advance the model by one edge using the current inputs, then clock the DUT.
    task automatic tick();
        int              pre;
        bit              popped;
        logic [TS_W-1:0] tsv;
        pre = mq.size();
        if (rst) begin
            mq.delete();
            m_ts   = 0;
            m_prev = 4'h0;
            m_ovf  = 1'b0;
            m_in   = 4'h0;
        end else begin
            popped = (pre > 0) && cap_ready;
            tsv    = TS_W'(m_ts);
            if (clr) begin
                mq.delete();
                m_ovf = 1'b0;
            end else begin
                if (popped) void'(mq.pop_front());
                if (out_port != m_prev) begin
                    if (pre < DEPTH || popped) mq.push_back({tsv, pcx(pc_out), out_port});
                    else m_ovf = 1'b1;
                end
            end
            m_prev = out_port;
            m_ts   = (m_ts + 1) % TS_MOD;
            if (host_we) m_in = host_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        clr       = 4'($urandom) > 7;
        out_port  = 4'($urandom);
        pc_out    = 4'($urandom);
        host_data = 4'($urandom);
        host_we   = 1'b1;
        cap_ready = 1'b1;
        tick();
        rst = 1'b0; clr = 1'b0; host_we = 1'b0; cap_ready = 1'b0; out_port = 4'h0;
        total += 5;
        if (cap_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", cap_valid); end
        if (cap_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", cap_count); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        if (cap_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", cap_data); end
        if (in_port !== 4'h0) begin bad++; $display("FAIL reset_in_port got=%h want=0", in_port); end
    endtask

    task automatic test_first_change();
        logic [3:0]      pc;
        logic [TS_W+7:0] want;
        do_reset();
        cap_ready = 1'b0;
        out_port  = 4'h0;
        repeat (3) tick();
        pc       = 4'($urandom);
        pc_out   = pc;
        out_port = 4'h5;
        tick();
        want = {12'd3, pcx(pc), 4'h5};
        total += 4;
        if (cap_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", cap_valid); end
        if (cap_count !== 4'd1) begin bad++; $display("FAIL first_count got=%0d want=1", cap_count); end
        if (cap_data !== want) begin bad++; $display("FAIL first_data got=%h want=%h", cap_data, want); end
        if (cap_data[7:4] !== pcx(pc)) begin
            bad++; $display("FAIL first_pc_field got=%h want=%h", cap_data[7:4], pcx(pc));
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            pc_out = 4'($urandom);
            tick();
            total++;
            if (cap_count !== 4'd1) begin bad++; $display("FAIL hold_count[%0d] got=%0d want=1", i, cap_count); end
        end
        cap_ready = 1'b1;
        tick();
        total += 2;
        if (cap_valid !== 1'b0) begin bad++; $display("FAIL hold_pop_valid got=%b want=0", cap_valid); end
        if (cap_count !== 4'd0) begin bad++; $display("FAIL hold_pop_count got=%0d want=0", cap_count); end
        tick();
        cap_ready = 1'b0;
        total++;
        if (cap_count !== 4'd0) begin bad++; $display("FAIL ready_empty_count got=%0d want=0", cap_count); end
    endtask

    task automatic test_overflow();
        logic [TS_W+7:0] exp_e[9];
        logic [3:0]      pc;
        do_reset();
        cap_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pc       = 4'($urandom);
            pc_out   = pc;
            out_port = 4'(i + 1);
            exp_e[i] = {TS_W'(i), pcx(pc), 4'(i + 1)};
            tick();
        end
        total += 2;
        if (cap_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", cap_count); end
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        cap_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total += 2;
            if (cap_valid !== 1'b1) begin bad++; $display("FAIL ovf_drain_valid[%0d] got=%b want=1", i, cap_valid); end
            if (cap_data !== exp_e[i]) begin
                bad++; $display("FAIL ovf_drain_data[%0d] got=%h want=%h", i, cap_data, exp_e[i]);
            end
            tick();
        end
        cap_ready = 1'b0;
        total += 2;
        if (cap_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained_valid got=%b want=0", cap_valid); end
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_full_pop_push();
        logic [3:0]      pc;
        logic [TS_W+7:0] want;
        do_reset();
        cap_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pc_out   = 4'($urandom);
            out_port = 4'(i + 1);
            tick();
        end
        pc        = 4'($urandom);
        pc_out    = pc;
        out_port  = 4'h9;
        cap_ready = 1'b1;
        tick();
        want = {12'd8, pcx(pc), 4'h9};
        total += 2;
        if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b want=0", overflow); end
        if (cap_count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d want=8", cap_count); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mq.size() == 0 || cap_data !== mq[0]) begin
                bad++; $display("FAIL fpp_drain[%0d] got=%h want=%h", i, cap_data,
                                mq.size() > 0 ? mq[0] : '0);
            end
            if (i == 7) begin
                total++;
                if (cap_data !== want) begin bad++; $display("FAIL fpp_last got=%h want=%h", cap_data, want); end
            end
            tick();
        end
        cap_ready = 1'b0;
    endtask

    task automatic test_in_port_clear();
        host_we   = 1'b1;
        host_data = 4'hA;
        tick();
        host_we   = 1'b0;
        host_data = 4'h5;
        total++;
        if (in_port !== 4'hA) begin bad++; $display("FAIL in_port_load got=%h want=a", in_port); end
        tick();
        total++;
        if (in_port !== 4'hA) begin bad++; $display("FAIL in_port_hold got=%h want=a", in_port); end
        cap_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            out_port = m_prev + 4'h1;
            tick();
        end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL clr_pre_ovf got=%b want=1", overflow); end
        clr      = 1'b1;
        out_port = m_prev + 4'h3;
        tick();
        clr = 1'b0;
        total += 4;
        if (cap_count !== 4'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", cap_count); end
        if (cap_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b want=0", cap_valid); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%b want=0", overflow); end
        if (in_port !== 4'hA) begin bad++; $display("FAIL clr_in_port got=%h want=a", in_port); end
        tick();
        total++;
        if (cap_count !== 4'd0) begin bad++; $display("FAIL clr_change_discard got=%0d want=0", cap_count); end
    endtask

    task automatic test_ts_wrap();
        do_reset();
        cap_ready = 1'b0;
        out_port  = 4'h0;
        repeat (TS_MOD + 1) tick();
        out_port = 4'h7;
        tick();
        total += 2;
        if (cap_count !== 4'd1) begin bad++; $display("FAIL wrap_count got=%0d want=1", cap_count); end
        if (cap_data[TS_W+7:8] !== 12'd1) begin
            bad++; $display("FAIL wrap_ts got=%0d want=1", cap_data[TS_W+7:8]);
        end
        out_port = 4'h3; tick();
        out_port = 4'h2; tick();
        cap_ready = 1'b1;
        tick();
        rst       = 1'b1;
        out_port  = 4'h9;
        host_we   = 1'b1;
        host_data = 4'hF;
        tick();
        rst = 1'b0; host_we = 1'b0; cap_ready = 1'b0;
        total += 5;
        if (cap_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", cap_valid); end
        if (cap_count !== 4'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", cap_count); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b want=0", overflow); end
        if (cap_data !== '0) begin bad++; $display("FAIL midrst_data got=%h want=0", cap_data); end
        if (in_port !== 4'h0) begin bad++; $display("FAIL midrst_in_port got=%h want=0", in_port); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 999) < 3);
            clr       = ($urandom_range(0, 99) < 2);
            cap_ready = ($urandom_range(0, 99) < 40);
            host_we   = ($urandom_range(0, 99) < 10);
            host_data = 4'($urandom);
            pc_out    = 4'($urandom);
            if ($urandom_range(0, 99) < 50) out_port = 4'($urandom);
            tick();
            total += 4;
            if (cap_count !== mq.size()) begin
                bad++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", i, cap_count, mq.size());
            end
            if (cap_valid !== (mq.size() > 0)) begin
                bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, cap_valid, mq.size() > 0);
            end
            if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf[%0d] got=%b want=%b", i, overflow, m_ovf); end
            if (in_port !== m_in) begin bad++; $display("FAIL rnd_in_port[%0d] got=%h want=%h", i, in_port, m_in); end
            if (mq.size() > 0) begin
                total++;
                if (cap_data !== mq[0]) begin
                    bad++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, cap_data, mq[0]);
                end
            end
        end
        rst = 1'b0; clr = 1'b0; host_we = 1'b0; cap_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; out_port = 4'h0; pc_out = 4'h0;
        host_data = 4'h0; host_we = 1'b0; cap_ready = 1'b0;
        m_ts = 0; m_prev = 4'h0; m_ovf = 1'b0; m_in = 4'h0;
        test_reset();
        test_first_change();
        test_hold();
        test_overflow();
        test_full_pop_push();
        test_in_port_clear();
        test_ts_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
